// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the mac_v2 multiply-accumulate block.
package mac_pkg;
  localparam int IN_W   = 4;
  localparam int OUT_W  = 10;
  localparam int PROD_W = 2 * IN_W;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } mac_state_e;
endpackage

// File: rtl/mac_mult.sv
// Unsigned IN_W x IN_W -> 2*IN_W combinational multiplier.
module mac_mult #(
  parameter int IN_W = mac_pkg::IN_W
) (
  input  logic [IN_W-1:0]   a_i,
  input  logic [IN_W-1:0]   b_i,
  output logic [2*IN_W-1:0] p_o
);
  // Full-width product of the zero-extended operands; cannot overflow.
  always_comb begin
    p_o = {{IN_W{1'b0}}, a_i} * {{IN_W{1'b0}}, b_i};
  end
endmodule

// File: rtl/mac_v2.sv
// Burst multiply-accumulate: sums operand-pair products while in_valid is
// high and strobes the wrapped OUT_W-bit sum for one cycle when the burst ends.
module mac_v2
  import mac_pkg::*;
#(
  parameter int IN_W  = mac_pkg::IN_W,
  parameter int OUT_W = mac_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,      // active-high despite the name
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in1_IFM,
  input  logic [IN_W-1:0]  in2_IFM,
  output logic             out_valid,
  output logic [OUT_W-1:0] out
);
  localparam int PW = 2 * IN_W;

  logic [PW-1:0]    prod;
  logic [OUT_W-1:0] prod_ext;
  mac_state_e       state_q;
  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] out_q;
  logic             out_valid_q;

  mac_mult #(.IN_W(IN_W)) u_mult (
    .a_i (in1_IFM),
    .b_i (in2_IFM),
    .p_o (prod)
  );

  // Zero-extend the product so the accumulator add wraps modulo 2^OUT_W.
  always_comb begin
    prod_ext = {{(OUT_W-PW){1'b0}}, prod};
  end

  // Burst FSM, accumulator and registered result strobe in one process.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // First pair of a burst loads a cleared accumulator.
            acc_q   <= prod_ext;
            state_q <= ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            acc_q <= acc_q + prod_ext;
          end else begin
            out_q       <= acc_q;
            out_valid_q <= 1'b1;
            acc_q       <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
endmodule

// File: tb/tb_mac_v2.sv
// Self-checking bench for mac_v2: directed test-plan bursts plus random traffic
// against a burst-sum reference model.
module tb_mac_v2;
  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in1_IFM;
  logic [3:0] in2_IFM;
  logic       out_valid;
  logic [9:0] out;

  int errs;
  int checks;

  // reference model: running burst sum and expected outputs after next edge
  int sum;
  bit in_burst;
  int exp_vld;
  int exp_out;
  int last_out;
  int nstrobe;

  mac_v2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1_IFM   (in1_IFM),
    .in2_IFM   (in2_IFM),
    .out_valid (out_valid),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive a pair (or idle), advance the model, check after the edge.
  task automatic cyc(input bit v, input int x, input int y);
    in_valid = v;
    in1_IFM  = 4'(x);
    in2_IFM  = 4'(y);
    if (v) begin
      in_burst = 1'b1;
      sum      = sum + (x % 16) * (y % 16);
      exp_vld  = 0;
      exp_out  = 0;
    end else if (in_burst) begin
      exp_vld  = 1;
      exp_out  = sum % 1024;
      sum      = 0;
      in_burst = 1'b0;
    end else begin
      exp_vld = 0;
      exp_out = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", int'(out_valid), exp_vld);
    chk("out", int'(out), exp_out);
    if (out_valid) begin
      last_out = int'(out);
      nstrobe++;
    end
  endtask

  // Assert reset mid-cycle with random inputs, hold, release on a negedge.
  task automatic do_reset(input int hold);
    #2;
    rst_n    = 1'b1;
    in_valid = 1'($urandom);
    in1_IFM  = 4'($urandom);
    in2_IFM  = 4'($urandom);
    #1;
    chk("rst_vld_async", int'(out_valid), 0);
    chk("rst_out_async", int'(out), 0);
    sum      = 0;
    in_burst = 1'b0;
    exp_vld  = 0;
    exp_out  = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rst_vld_hold", int'(out_valid), 0);
      chk("rst_out_hold", int'(out), 0);
      in_valid = 1'($urandom);
      in1_IFM  = 4'($urandom);
      in2_IFM  = 4'($urandom);
    end
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errs = 0; checks = 0;
    sum = 0; in_burst = 1'b0; exp_vld = 0; exp_out = 0;
    last_out = -1; nstrobe = 0;
    rst_n = 1'b0; in_valid = 1'b0; in1_IFM = '0; in2_IFM = '0;

    do_reset(3);

    // single full-scale pair
    nstrobe = 0;
    cyc(1, 15, 15); cyc(0, 0, 0); cyc(0, 0, 0);
    chk("single_res", last_out, 225);
    chk("single_cnt", nstrobe, 1);

    // three-pair burst
    nstrobe = 0;
    cyc(1, 1, 2); cyc(1, 3, 4); cyc(1, 5, 6); cyc(0, 9, 9); cyc(0, 0, 0);
    chk("three_res", last_out, 44);
    chk("three_cnt", nstrobe, 1);

    // four full-scale pairs: exact
    for (int i = 0; i < 4; i++) cyc(1, 15, 15);
    cyc(0, 0, 0); cyc(0, 0, 0);
    chk("full4_res", last_out, 900);

    // five full-scale pairs: wraps
    for (int i = 0; i < 5; i++) cyc(1, 15, 15);
    cyc(0, 0, 0); cyc(0, 0, 0);
    chk("wrap5_res", last_out, 101);

    // reset after 2 of 4 pairs, then a fresh single-pair burst
    nstrobe = 0;
    cyc(1, 15, 15); cyc(1, 15, 15);
    do_reset(1);
    cyc(1, 2, 3); cyc(0, 0, 0); cyc(0, 0, 0);
    chk("abort_res", last_out, 6);
    chk("abort_cnt", nstrobe, 1);

    // back-to-back: second burst starts during first result strobe
    nstrobe = 0;
    cyc(1, 7, 8); cyc(0, 0, 0);
    chk("b2b_first", last_out, 56);
    cyc(1, 0, 9); cyc(1, 4, 4); cyc(0, 0, 0); cyc(0, 0, 0);
    chk("b2b_second", last_out, 16);
    chk("b2b_cnt", nstrobe, 2);

    // random traffic with occasional mid-stream reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(0, 2));
      else cyc(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)));
    end
    cyc(0, 0, 0); cyc(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
